progmem_fetch_master: RTL
=========================

Name: progmem_fetch_master

Overview:
- Initiator-side read engine for the 10-bit word-addressed program-memory control interface (address / read / readdata / response / waitrequest).
- Given a start word address and a word count, it issues sequential single-word reads and buffers the returned words in a small FIFO.
- The buffered words are presented as a valid/ready stream to the consumer, for example a boot loader or DSI init-sequence player.
- Sits between the consumer logic and the program-memory responder; it is the only master on that port.

Parameters:
- FIFO_DEPTH, 4, output buffer depth in words; power of two, minimum 2.
- ADDR_W, 10, word address width on the memory port.
- CNT_W, 11, width of the word-count input; range 0..1024.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle pulse; begins a burst. Ignored while busy.
- start_addr  in  ADDR_W  first word address; sampled on start.
- word_count  in  CNT_W  number of words to fetch; sampled on start.
- abort  in  1  stops issuing new reads and flushes the FIFO.
- busy  out  1  high from the cycle after an accepted start until the burst completes.
- done  out  1  one-cycle pulse when the burst ends (normally, by error, or by abort).
- error  out  1  sticky; set on a nonzero response; cleared by the next accepted start.
- out_valid  out  1  FIFO not empty.
- out_data  out  32  FIFO head word.
- out_ready  in  1  consumer accepts the head word when out_valid && out_ready.
- mem_address  out  ADDR_W  read word address.
- mem_read  out  1  read request.
- mem_readdata  in  32  read data.
- mem_response  in  2  00 = OK; any other value = error.
- mem_waitrequest  in  1  stall from the responder.

Behaviour:
- Reset values: busy=0, done=0, error=0, out_valid=0, mem_read=0, mem_address=0, FIFO empty, state=IDLE.
- Transfer rule:
  - A read completes in the cycle where mem_read=1 and mem_waitrequest=0.
  - mem_readdata and mem_response are sampled in that same cycle.
  - While mem_waitrequest=1, mem_read and mem_address are held stable.
  - At most one read is outstanding.
- States:
  - IDLE: on start with word_count=0, pulse done next cycle; busy stays 0. On start with word_count>0, latch address and count, set busy, clear error, go to ISSUE.
  - ISSUE: mem_read=1 only when FIFO free slots >= 1, counting a pop in the same cycle as freeing a slot.
    - On a completed read with response OK: push data, increment address, decrement remaining count.
    - If remaining count reaches 0, go to FINISH.
    - With mem_read low, the engine waits in ISSUE.
  - ISSUE, error case: on a completed read with response != 0, do not push, set error, go to FINISH.
  - FINISH: pulse done for one cycle, clear busy, go to IDLE. Words already in the FIFO remain drainable.
- Address arithmetic: mem_address increments modulo 2^ADDR_W, so 1023 wraps to 0.
- Count width: a word_count above 1024 saturates to 1024.
- Abort:
  - In IDLE: only flushes the FIFO.
  - In ISSUE with no read asserted: go straight to FINISH and flush the FIFO.
  - In ISSUE with a read pending under waitrequest: keep mem_read asserted until the transfer completes (no request withdrawal), discard the returned data, then go to FINISH.
  - The FIFO is flushed in the abort cycle. out_valid is 0 from the next cycle.
- FIFO:
  - Simultaneous push and pop when full or empty is legal; the count stays unchanged.
  - Output is first-word-fall-through: out_data is valid in the same cycle as out_valid.
  - No push is allowed when full; the issue gating above guarantees this.
- start while busy is ignored, with no effect on latched values.
- rst mid-burst returns every output to its reset value on the next edge. mem_read drops even if waitrequest is high.

Test Plan:
- Basic burst: start_addr=5, word_count=3, responder waitrequest for 1 cycle per read, out_ready=1 -> reads at addresses 5, 6, 7; out_data sequence equals ROM[5..7]; done pulses once; error=0.
- Backpressure: word_count=8, out_ready=0 -> exactly 4 reads complete, then mem_read=0. Raise out_ready -> remaining 4 reads issue and all 8 words arrive in order.
- Wrap-around: start_addr=1022, word_count=4 -> addresses 1022, 1023, 0, 1.
- Error: mem_response=2'b01 on the 2nd read of a 5-word burst -> 1 word delivered, error=1, done pulse, no further reads.
- Abort under wait: abort asserted while mem_waitrequest=1 -> mem_read held until waitrequest=0, then done pulse; out_valid=0 afterwards; no extra read issued.
- Zero count, and start while busy: word_count=0 -> done pulse, no mem_read. start during a busy burst -> ignored; addresses continue unchanged.

Source files
------------

// File: rtl/progmem_fetch_master.sv
// -----------------------------------------------------------------------------
// progmem_fetch_master
//
// Read engine for the word-addressed program-memory port. After a start pulse
// it issues sequential single-word reads beginning at start_addr, buffers the
// returned words in a small first-word-fall-through FIFO and presents them to
// the consumer as a valid/ready stream.
//
// Handshakes:
//   Memory side: a read completes in the cycle where mem_read=1 and
//   mem_waitrequest=0; mem_readdata/mem_response are sampled in that cycle.
//   While mem_waitrequest=1 the request (mem_read, mem_address) is held.
//   Stream side: a word moves when out_valid && out_ready; out_data is the
//   FIFO head and is valid whenever out_valid is high.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start                 one-cycle pulse, begins a burst (ignored while busy)
//   start_addr            first word address, sampled on start
//   word_count            words to fetch (saturates at 2^ADDR_W), sampled on start
//   abort                 stop issuing reads and flush the FIFO
//   busy                  burst in progress
//   done                  one-cycle pulse when a burst ends
//   error                 sticky, set on a nonzero response
//   out_valid/out_data    FIFO head stream, accepted with out_ready
//   mem_*                 program-memory initiator port
//   state_dbg             current FSM state (debug observation)
// -----------------------------------------------------------------------------
module progmem_fetch_master #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 10,
    parameter int CNT_W      = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [CNT_W-1:0]  word_count,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              out_valid,
    output logic [31:0]       out_data,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    input  logic [31:0]       mem_readdata,
    input  logic [1:0]        mem_response,
    input  logic              mem_waitrequest,
    output logic [1:0]        state_dbg
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]  MAX_WORDS = CNT_W'(1 << ADDR_W);
    localparam logic [FCNT_W-1:0] FULL_CNT  = FCNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [CNT_W-1:0]    rem_q;
    logic                busy_q;
    logic                done_q;
    logic                error_q;
    logic                aborting_q;   // abort arrived while a read was stalled

    logic [31:0]         fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [FCNT_W-1:0]   fcnt_q;

    logic                pop;
    logic                push;
    logic                fifo_full;
    logic                xfer;
    logic                resp_ok;
    logic                read_req;
    logic [CNT_W-1:0]    sat_count;

    assign sat_count = (word_count > MAX_WORDS) ? MAX_WORDS : word_count;

    assign out_valid = (fcnt_q != '0);
    assign out_data  = fifo_mem_q[rd_ptr_q];
    assign pop       = out_valid && out_ready;
    assign fifo_full = (fcnt_q == FULL_CNT);

    // A slot freed by a same-cycle pop counts as free. Once raised, the request
    // cannot drop before completion: the FIFO only fills on a completed read,
    // and an abort during a stall is carried by aborting_q.
    assign read_req = (state_q == S_ISSUE) && (aborting_q || !fifo_full || pop);
    assign xfer     = read_req && !mem_waitrequest;
    assign resp_ok  = (mem_response == 2'b00);

    // Returned data is dropped on error, in the abort cycle, and for the
    // stalled read that an earlier abort let finish.
    assign push = xfer && resp_ok && !abort && !aborting_q;

    assign mem_read    = read_req;
    assign mem_address = addr_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign state_dbg   = state_q;

    // Control FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            aborting_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (sat_count == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            addr_q  <= start_addr;
                            rem_q   <= sat_count;
                            busy_q  <= 1'b1;
                            error_q <= 1'b0;
                            state_q <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (aborting_q) begin
                        if (xfer) begin
                            aborting_q <= 1'b0;
                            state_q    <= S_FINISH;
                        end
                    end else if (abort) begin
                        // A request cannot be withdrawn under waitrequest.
                        if (read_req && mem_waitrequest) begin
                            aborting_q <= 1'b1;
                        end else begin
                            state_q <= S_FINISH;
                        end
                    end else if (xfer) begin
                        if (!resp_ok) begin
                            error_q <= 1'b1;
                            state_q <= S_FINISH;
                        end else begin
                            addr_q <= addr_q + ADDR_W'(1);
                            rem_q  <= rem_q - CNT_W'(1);
                            if (rem_q == CNT_W'(1)) begin
                                state_q <= S_FINISH;
                            end
                        end
                    end
                end
                S_FINISH: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy; abort flushes in any state.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fcnt_q   <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fcnt_q <= fcnt_q + FCNT_W'(1);
                2'b01:   fcnt_q <= fcnt_q - FCNT_W'(1);
                default: fcnt_q <= fcnt_q;
            endcase
        end
    end

    // FIFO storage carries no reset; out_valid qualifies its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= mem_readdata;
        end
    end

endmodule
